// File: rtl/nco_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl_if
//   Control/status bundle between a sweep requester and nco_sweep_ctrl.
//   The master side issues start/abort and configuration. The slave side is
//   the sweep controller, which returns the NCO drive and the sweep status.
// ---------------------------------------------------------------------------
interface nco_sweep_ctrl_if #(
  parameter int APR = 13,
  parameter int DWW = 16
);

  logic           start;
  logic           abort;
  logic [APR-1:0] cfg_start_inc;
  logic [APR-1:0] cfg_stop_inc;
  logic [APR-1:0] cfg_step;
  logic [DWW-1:0] cfg_dwell;
  logic           cfg_loop;

  logic [APR-1:0] phi_inc_o;
  logic           nco_clken_o;
  logic           busy;
  logic           done;
  logic           cfg_err;
  logic [7:0]     sweep_cnt;

  modport master (
    output start, abort, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell, cfg_loop,
    input  phi_inc_o, nco_clken_o, busy, done, cfg_err, sweep_cnt
  );

  modport slave (
    input  start, abort, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell, cfg_loop,
    output phi_inc_o, nco_clken_o, busy, done, cfg_err, sweep_cnt
  );

endinterface

// File: rtl/nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl
//   Frequency-sweep sequencer for an NCO. It steps the phase increment from
//   start_inc towards stop_inc in units of step and holds each value for
//   dwell+1 cycles. When stop is passed, the sweep either finishes with a
//   one-cycle done pulse or restarts when loop mode is enabled.
//
//   Optional feature macro: NCO_SWEEP_BIDIR_EN
//     undefined : sawtooth sweep (up, then finish or wrap to start_inc)
//     defined   : triangle sweep (up to stop, then back down to start_inc)
//
//   All outputs are registered. Reset is synchronous and active-high.
// ---------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int APR = 13,
  parameter int DWW = 16
) (
  input  logic             clk,
  input  logic             reset,
  nco_sweep_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DWELL_UP = 2'd1;
  localparam logic [1:0] DWELL_DN = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]     state;
  logic [APR-1:0] phi_q;
  logic [DWW-1:0] dwell_cnt;
  logic [7:0]     cnt_q;
  logic           busy_q;
  logic           clken_q;
  logic           done_q;
  logic           err_q;

  // Configuration captured when a start is accepted.
  logic [APR-1:0] start_q;
  logic [APR-1:0] stop_q;
  logic [APR-1:0] step_q;
  logic [DWW-1:0] dwell_q;
  logic           loop_q;

  logic           cfg_bad;
  logic           dwell_tc;
  logic [APR:0]   up_sum;
  logic           up_pass;
  logic           sweep_end;
  logic [APR-1:0] restart_val;

`ifdef NCO_SWEEP_BIDIR_EN
  logic [APR:0]   dn_diff;
  logic           dn_pass;
  logic [APR:0]   rs_sum;
`endif

  // Step arithmetic, sweep-end detection and restart value.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    cfg_bad     = (bus.cfg_step == '0) || (bus.cfg_start_inc > bus.cfg_stop_inc);
    dwell_tc    = (dwell_cnt == '0);
    // One extra bit keeps the carry, so a wrap past the top counts as passing stop.
    up_sum      = {1'b0, phi_q} + {1'b0, step_q};
    up_pass     = (up_sum > {1'b0, stop_q});
    sweep_end   = 1'b0;
    restart_val = start_q;
`ifdef NCO_SWEEP_BIDIR_EN
    // A borrow sets the top bit and counts as passing start_inc.
    dn_diff     = {1'b0, phi_q} - {1'b0, step_q};
    dn_pass     = dn_diff[APR] || (dn_diff[APR-1:0] < start_q);
    rs_sum      = {1'b0, start_q} + {1'b0, step_q};
    // A looping triangle does not repeat start_inc at the turnaround.
    restart_val = (rs_sum > {1'b0, stop_q}) ? start_q : rs_sum[APR-1:0];
    // A sweep ends when the down step passes start_inc. This can also happen
    // directly at the top, when no down step fits.
    if (dwell_tc) begin
      if (state == DWELL_UP)      sweep_end = up_pass && dn_pass;
      else if (state == DWELL_DN) sweep_end = dn_pass;
    end
`else
    if (dwell_tc && (state == DWELL_UP)) sweep_end = up_pass;
`endif
  end

  // Sweep state machine and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (reset) begin
      state     <= IDLE;
      phi_q     <= '0;
      dwell_cnt <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      clken_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
    end else begin
      // done and cfg_err are single-cycle pulses.
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (bus.abort) begin
        // Abort overrides start and terminal count. phi_inc_o keeps its value.
        state     <= IDLE;
        busy_q    <= 1'b0;
        clken_q   <= 1'b0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (cfg_bad) begin
                err_q <= 1'b1;
              end else begin
                start_q   <= bus.cfg_start_inc;
                stop_q    <= bus.cfg_stop_inc;
                step_q    <= bus.cfg_step;
                dwell_q   <= bus.cfg_dwell;
                loop_q    <= bus.cfg_loop;
                phi_q     <= bus.cfg_start_inc;
                dwell_cnt <= bus.cfg_dwell;
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                clken_q   <= 1'b1;
                state     <= DWELL_UP;
              end
            end
          end

          DWELL_UP, DWELL_DN: begin
            if (!dwell_tc) begin
              dwell_cnt <= dwell_cnt - DWW'(1);
            end else begin
              dwell_cnt <= dwell_q;
              if (sweep_end) begin
                cnt_q <= cnt_q + 8'd1;
                if (loop_q) begin
                  phi_q <= restart_val;
                  state <= DWELL_UP;
                end else begin
                  state   <= DONE;
                  busy_q  <= 1'b0;
                  clken_q <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else if ((state == DWELL_UP) && !up_pass) begin
                phi_q <= up_sum[APR-1:0];
`ifdef NCO_SWEEP_BIDIR_EN
              end else begin
                // Either turning around at the top or continuing down.
                phi_q <= dn_diff[APR-1:0];
                state <= DWELL_DN;
`endif
              end
            end
          end

          DONE: begin
            // A start seen here is ignored. It is taken in IDLE only if still asserted.
            state <= IDLE;
          end

          default: begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            clken_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Outputs driven directly from the registers.
  assign bus.phi_inc_o   = phi_q;
  assign bus.nco_clken_o = clken_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = err_q;
  assign bus.sweep_cnt   = cnt_q;

endmodule
